lcd_char_driver: RTL and testbench
==================================

LCD_CHAR_DRIVER -- requirements
Module: lcd_char_driver

Interface
REQ-001 The block SHALL have parameter PWR_CYC, default 750000, setting the power-on wait in clk cycles (15 ms at 50 MHz).
REQ-002 The block SHALL have parameter CMD_CYC, default 2500, setting the post-write wait for ordinary commands and data in cycles (50 us).
REQ-003 The block SHALL have parameter CLR_CYC, default 100000, setting the post-write wait after clear-display 0x01 in cycles (2 ms).
REQ-004 The block SHALL have parameter E_CYC, default 25, setting the enable-high width in cycles (500 ns).
REQ-005 Port clk SHALL be an input, 1 bit wide: the single system clock.
REQ-006 Port rst SHALL be an input, 1 bit wide: reset, synchronous, active-low.
REQ-007 Port line1 SHALL be an input, 128 bits wide: top-row ASCII; [127:120] is column 0 and [7:0] is column 15.
REQ-008 Port line2 SHALL be an input, 128 bits wide: bottom-row ASCII, packed the same way as line1.
REQ-009 Port lcd_e SHALL be an output, 1 bit wide: HD44780 enable strobe.
REQ-010 Port lcd_rs SHALL be an output, 1 bit wide: 0 = command, 1 = data.
REQ-011 Port lcd_rw SHALL be an output, 1 bit wide: tied to 0 (write only).
REQ-012 Port lcd_data SHALL be an output, 8 bits wide: byte bus in 8-bit mode.
REQ-013 Port init_done SHALL be an output, 1 bit wide: high once the init sequence is complete.
REQ-014 Port frame_done SHALL be an output, 1 bit wide: one-cycle pulse at the end of each full two-row write.

Function
REQ-015 Every byte write SHALL be a slot of 1 setup cycle (lcd_e=0; lcd_rs/lcd_data valid), then E_CYC cycles with lcd_e=1, then W cycles with lcd_e=0, where W=CLR_CYC for 0x01 and CMD_CYC otherwise.
REQ-016 lcd_rs and lcd_data SHALL stay stable for the whole slot and SHALL change only at the setup cycle of the next slot.
REQ-017 The FSM states SHALL be PWR_WAIT, INIT_CMD, IDLE, ADDR1, LINE1, ADDR2, LINE2.
REQ-018 PWR_WAIT SHALL count PWR_CYC cycles with lcd_e=0, then enter INIT_CMD.
REQ-019 INIT_CMD SHALL write commands 0x38, 0x0C, 0x06, 0x01 in order with RS=0.
REQ-020 INIT_CMD SHALL then set init_done=1 and enter IDLE.
REQ-021 On IDLE→ADDR1, the block SHALL snapshot line1 and line2 into internal registers; all frame data SHALL come from the snapshot.
REQ-022 ADDR1 SHALL write 0x80 with RS=0.
REQ-023 LINE1 SHALL write 16 data bytes with RS=1, column 0 first.
REQ-024 ADDR2 SHALL write 0xC0 with RS=0.
REQ-025 LINE2 SHALL write 16 data bytes with RS=1.
REQ-026 frame_done SHALL pulse in the last wait cycle of the 16th LINE2 byte, and the FSM SHALL then return to IDLE.
REQ-027 Input changes during a frame SHALL NOT affect that frame (no tearing).
REQ-028 The column counter SHALL be 4 bits and wrap 15→0 exactly when leaving LINE1 or LINE2.
REQ-029 Slot-timing counters SHALL be wide enough for max(PWR_CYC, CLR_CYC) with no overflow.

Reset
REQ-030 When rst=0 at a clk edge, the block SHALL set lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, init_done=0, frame_done=0, the snapshot registers to 0x20 (space) and state to PWR_WAIT.
REQ-031 A reset mid-slot or mid-frame SHALL abort immediately and, after release, rerun the full power wait and init sequence.

Configuration
REQ-032 With macro LCD_CHANGE_DETECT_EN defined, IDLE SHALL start a frame only when {line1,line2} differs from the snapshot, or on the first frame after init.
REQ-033 Without LCD_CHANGE_DETECT_EN, IDLE SHALL last exactly one cycle and frames SHALL repeat continuously.

Structure
REQ-034 The FSM state encoding and command constants (0x38, 0x0C, 0x06, 0x01, 0x80, 0xC0) SHALL live in shared package lcd_pkg.
REQ-035 Slot timing SHALL be implemented in sub-module lcd_byte_writer with a start/rs/byte input, a done pulse and the lcd_e/lcd_rs/lcd_data outputs.

Verification (PWR_CYC=20, CMD_CYC=4, CLR_CYC=8, E_CYC=2)
REQ-036 Reset release → lcd_e=0 for 20 cycles, then bytes 38,0C,06,01 with RS=0 and init_done rising after the 0x01 slot (7+7+7+11 cycles).
REQ-037 line1="PRESS * TO START", line2="MONEY: 01000" → captured bus shows 0x80, then "PRESS * TO START", then 0xC0, then "MONEY: 01000", with frame_done pulsing once and each slot 7 cycles.
REQ-038 Change line1 to all "A" during the LINE1 write → the current frame still shows the old text and the next frame shows "AAAA...".
REQ-039 Assert rst=0 for 1 cycle during the 8th LINE2 byte → all outputs reset the next cycle and the 20-cycle power wait restarts.
REQ-040 With LCD_CHANGE_DETECT_EN and static inputs → exactly one frame after init and no further lcd_e pulses; changing one character → exactly one new frame.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared FSM encodings, HD44780 command bytes and small helpers for the
// LCD character driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_CMD,
    IDLE,
    ADDR1,
    LINE1,
    ADDR2,
    LINE2
  } lcd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_SETUP,
    WR_HIGH,
    WR_WAIT
  } wr_phase_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ADDR1    = 8'h80;
  localparam logic [7:0] CMD_ADDR2    = 8'hC0;
  localparam logic [7:0] CHAR_SPACE   = 8'h20;
  localparam logic [1:0] INIT_LAST    = 2'd3;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  // Column 0 sits in the top byte of the packed row.
  function automatic logic [7:0] col_char(input logic [127:0] line, input logic [3:0] col);
    logic [127:0] shifted;
    shifted = line << {col, 3'b000};
    return shifted[127:120];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 byte slot: setup cycle, E_CYC enable-high cycles, then a wait
// whose length depends on the byte; done pulses in the last wait cycle.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int E_CYC   = 25,
  parameter int CMD_CYC = 2500,
  parameter int CLR_CYC = 100000,
  parameter int CNT_W   = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  wr_phase_t        phase, next_phase;
  logic [CNT_W-1:0] cnt;
  logic             is_clear;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) phase <= WR_IDLE;
    else      phase <= next_phase;
  end

  always_comb begin
    next_phase = phase;
    if (start) begin
      next_phase = WR_SETUP;
    end else begin
      case (phase)
        WR_SETUP: next_phase = WR_HIGH;
        WR_HIGH:  if (cnt_zero) next_phase = WR_WAIT;
        WR_WAIT:  if (cnt_zero) next_phase = WR_IDLE;
        default:  next_phase = phase;
      endcase
    end
  end

  always_comb begin
    lcd_e = (phase == WR_HIGH);
    done  = (phase == WR_WAIT) && cnt_zero;
  end

  // The byte is latched once at start so the bus cannot move mid-slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= '0;
      is_clear <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (start) begin
      cnt      <= '0;
      is_clear <= !rs && (data == CMD_CLEAR);
      lcd_rs   <= rs;
      lcd_data <= data;
    end else begin
      case (phase)
        WR_SETUP: cnt <= CNT_W'(E_CYC - 1);
        WR_HIGH: begin
          if (cnt_zero) cnt <= is_clear ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
          else          cnt <= cnt - 1'b1;
        end
        WR_WAIT:  if (!cnt_zero) cnt <= cnt - 1'b1;
        default:  cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/lcd_char_driver.sv
// HD44780 8-bit driver: power wait, init commands, then two 16-char rows from
// a per-frame snapshot. Define LCD_CHANGE_DETECT_EN to redraw only on change.
module lcd_char_driver
  import lcd_pkg::*;
#(
  parameter int PWR_CYC = 750000,
  parameter int CMD_CYC = 2500,
  parameter int CLR_CYC = 100000,
  parameter int E_CYC   = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] line1,
  input  logic [127:0] line2,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  localparam int MAX_A   = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
  localparam int MAX_B   = (CMD_CYC > E_CYC) ? CMD_CYC : E_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  lcd_state_t       state, next_state;
  logic [3:0]       col, next_col;
  logic [CNT_W-1:0] pwr_cnt;
  logic [127:0]     snap1, snap2;
  logic             advance;
  logic             go;
  logic             wr_start, wr_rs, wr_done;
  logic [7:0]       wr_byte;

  assign lcd_rw = 1'b0;

`ifdef LCD_CHANGE_DETECT_EN
  logic first_frame;

  always_ff @(posedge clk) begin
    if (!rst)                                    first_frame <= 1'b1;
    else if (state == IDLE && next_state == ADDR1) first_frame <= 1'b0;
  end

  assign go = first_frame || ({line1, line2} != {snap1, snap2});
`else
  assign go = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= PWR_WAIT;
    else      state <= next_state;
  end

  // advance marks the cycle in which the next slot must be launched, so
  // consecutive slots abut with no idle cycle between them.
  always_comb begin
    next_state = state;
    next_col   = col;
    advance    = 1'b0;
    case (state)
      PWR_WAIT: begin
        if (pwr_cnt == CNT_W'(PWR_CYC - 1)) begin
          next_state = INIT_CMD;
          next_col   = 4'd0;
          advance    = 1'b1;
        end
      end
      INIT_CMD: begin
        if (wr_done) begin
          advance = 1'b1;
          if (col[1:0] == INIT_LAST) begin
            next_state = IDLE;
            next_col   = 4'd0;
          end else begin
            next_col = col + 4'd1;
          end
        end
      end
      IDLE: begin
        if (go) begin
          next_state = ADDR1;
          next_col   = 4'd0;
          advance    = 1'b1;
        end
      end
      ADDR1: begin
        if (wr_done) begin
          next_state = LINE1;
          next_col   = 4'd0;
          advance    = 1'b1;
        end
      end
      LINE1: begin
        if (wr_done) begin
          advance  = 1'b1;
          next_col = col + 4'd1;
          if (col == 4'd15) next_state = ADDR2;
        end
      end
      ADDR2: begin
        if (wr_done) begin
          next_state = LINE2;
          next_col   = 4'd0;
          advance    = 1'b1;
        end
      end
      LINE2: begin
        if (wr_done) begin
          advance  = 1'b1;
          next_col = col + 4'd1;
          if (col == 4'd15) next_state = IDLE;
        end
      end
      default: next_state = PWR_WAIT;
    endcase
  end

  always_comb begin
    wr_start   = advance && (next_state != IDLE);
    wr_rs      = 1'b0;
    wr_byte    = 8'h00;
    frame_done = (state == LINE2) && (col == 4'd15) && wr_done;
    case (next_state)
      INIT_CMD: wr_byte = init_cmd(next_col[1:0]);
      ADDR1:    wr_byte = CMD_ADDR1;
      LINE1: begin
        wr_rs   = 1'b1;
        wr_byte = col_char(snap1, next_col);
      end
      ADDR2:    wr_byte = CMD_ADDR2;
      LINE2: begin
        wr_rs   = 1'b1;
        wr_byte = col_char(snap2, next_col);
      end
      default:  wr_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col       <= 4'd0;
      pwr_cnt   <= '0;
      snap1     <= {16{CHAR_SPACE}};
      snap2     <= {16{CHAR_SPACE}};
      init_done <= 1'b0;
    end else begin
      col <= next_col;
      if (state == PWR_WAIT) pwr_cnt <= pwr_cnt + 1'b1;
      if (state == IDLE && next_state == ADDR1) begin
        snap1 <= line1;
        snap2 <= line2;
      end
      if (state == INIT_CMD && next_state == IDLE) init_done <= 1'b1;
    end
  end

  lcd_byte_writer #(
    .E_CYC  (E_CYC),
    .CMD_CYC(CMD_CYC),
    .CLR_CYC(CLR_CYC),
    .CNT_W  (CNT_W)
  ) u_writer (
    .clk     (clk),
    .rst     (rst),
    .start   (wr_start),
    .rs      (wr_rs),
    .data    (wr_byte),
    .done    (wr_done),
    .lcd_e   (lcd_e),
    .lcd_rs  (lcd_rs),
    .lcd_data(lcd_data)
  );

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver with short timing parameters; build with
// LCD_CHANGE_DETECT_EN defined to exercise the change-detect variant.
module tb_lcd_char_driver;

  localparam logic [127:0] TXT1 = "PRESS * TO START";
  localparam logic [127:0] TXT2 = "MONEY: 01000    ";
  localparam logic [127:0] TXTA = {16{8'h41}};

  logic         clk;
  logic         rst;
  logic [127:0] line1, line2;
  logic         lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0]   lcd_data;

  int tests_run;
  int tests_failed;
  int sample_n;
  int base;
  int stab_err;

  int         rise_t[$];
  logic [8:0] rise_b[$];
  int         fd_t[$];
  int         idn_t[$];
  logic       prev_e, prev_idn, pend;
  logic [8:0] prev_bus;

  lcd_char_driver #(
    .PWR_CYC(20),
    .CMD_CYC(4),
    .CLR_CYC(8),
    .E_CYC  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .line1     (line1),
    .line2     (line2),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor: logs enable rises, frame_done and init_done edges relative
  // to the last reset release, and flags any bus change outside a setup cycle.
  initial begin
    sample_n = 0; base = 0; stab_err = 0;
    prev_e = 1'b0; prev_idn = 1'b0; pend = 1'b0; prev_bus = 9'h000;
  end

  always @(posedge clk) begin
    #1;
    sample_n++;
    if (rst) begin
      if (({lcd_rs, lcd_data} != prev_bus) && (lcd_e || prev_e)) stab_err++;
      if (pend && !(lcd_e && !prev_e)) stab_err++;
      pend = ({lcd_rs, lcd_data} != prev_bus);
    end else begin
      pend = 1'b0;
    end
    if (lcd_e && !prev_e) begin
      rise_t.push_back(sample_n - base);
      rise_b.push_back({lcd_rs, lcd_data});
    end
    if (frame_done) fd_t.push_back(sample_n - base);
    if (init_done && !prev_idn) idn_t.push_back(sample_n - base);
    prev_e   = lcd_e;
    prev_idn = init_done;
    prev_bus = {lcd_rs, lcd_data};
  end

  function automatic logic [7:0] char_at(input logic [127:0] l, input int i);
    return l[127 - 8*i -: 8];
  endfunction

  task automatic wait_rel(input int t);
    while ((sample_n - base) < t) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    base = sample_n;
    rise_t.delete(); rise_b.delete(); fd_t.delete(); idn_t.delete();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (lcd_e !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_e got %b want 0", lcd_e); end
    tests_run++; if (lcd_rs !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rs got %b want 0", lcd_rs); end
    tests_run++; if (lcd_rw !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rw got %b want 0", lcd_rw); end
    tests_run++; if (lcd_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_data got %h want 00", lcd_data); end
    tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_init_done got %b want 0", init_done); end
    tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
    release_reset();
  endtask

  task automatic check_init(input string tag);
    logic [7:0] cmds[4];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    wait_rel(60);
    tests_run++;
    if (rise_t.size() < 4) begin
      tests_failed++;
      $display("[TB] FAIL %s_count got %0d rises want >=4", tag, rise_t.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (rise_t[i] !== 21 + 7*i) begin
          tests_failed++;
          $display("[TB] FAIL %s_time%0d got %0d want %0d", tag, i, rise_t[i], 21 + 7*i);
        end
        tests_run++;
        if (rise_b[i] !== {1'b0, cmds[i]}) begin
          tests_failed++;
          $display("[TB] FAIL %s_byte%0d got %h want %h", tag, i, rise_b[i], {1'b0, cmds[i]});
        end
      end
    end
    tests_run++;
    if (idn_t.size() != 1 || idn_t[0] != 52) begin
      tests_failed++;
      $display("[TB] FAIL %s_init_done got %0d rises first %0d want 1 rise at 52",
               tag, idn_t.size(), (idn_t.size() > 0) ? idn_t[0] : -1);
    end
  endtask

  task automatic test_power_init();
    check_init("init");
  endtask

  task automatic test_frame();
    logic [8:0] exp_b[34];
    int bad_len;
    exp_b[0]  = {1'b0, 8'h80};
    exp_b[17] = {1'b0, 8'hC0};
    for (int i = 0; i < 16; i++) begin
      exp_b[1 + i]  = {1'b1, char_at(TXT1, i)};
      exp_b[18 + i] = {1'b1, char_at(TXT2, i)};
    end
    wait_rel(300);
    tests_run++;
    if (rise_t.size() < 38) begin
      tests_failed++;
      $display("[TB] FAIL frame_count got %0d rises want >=38", rise_t.size());
    end else begin
      tests_run++;
      if (rise_t[4] !== 54) begin
        tests_failed++;
        $display("[TB] FAIL frame_start got %0d want 54", rise_t[4]);
      end
      for (int i = 0; i < 34; i++) begin
        tests_run++;
        if (rise_b[4 + i] !== exp_b[i]) begin
          tests_failed++;
          $display("[TB] FAIL frame_byte%0d got %h want %h", i, rise_b[4 + i], exp_b[i]);
        end
      end
      bad_len = 0;
      for (int i = 4; i < 37; i++) if (rise_t[i + 1] - rise_t[i] != 7) bad_len++;
      tests_run++;
      if (bad_len != 0) begin
        tests_failed++;
        $display("[TB] FAIL slot_len got %0d slots not 7 cycles want 0", bad_len);
      end
    end
    tests_run++;
    if (fd_t.size() != 1 || fd_t[0] != 290) begin
      tests_failed++;
      $display("[TB] FAIL frame_done got %0d pulses first %0d want 1 at 290",
               fd_t.size(), (fd_t.size() > 0) ? fd_t[0] : -1);
    end
  endtask

`ifdef LCD_CHANGE_DETECT_EN
  task automatic test_change_detect();
    wait_rel(700);
    tests_run++;
    if (rise_t.size() != 38) begin
      tests_failed++;
      $display("[TB] FAIL static_rises got %0d want 38", rise_t.size());
    end
    @(negedge clk);
    line2[7:0] = 8'h21;
    wait_rel(1300);
    tests_run++;
    if (rise_t.size() != 72) begin
      tests_failed++;
      $display("[TB] FAIL change_rises got %0d want 72", rise_t.size());
    end else begin
      tests_run++;
      if (rise_b[71] !== {1'b1, 8'h21}) begin
        tests_failed++;
        $display("[TB] FAIL change_last_byte got %h want 121", rise_b[71]);
      end
    end
    tests_run++;
    if (fd_t.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL change_frames got %0d want 2", fd_t.size());
    end
    tests_run++;
    if (stab_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL bus_stable got %0d violations want 0", stab_err);
    end
  endtask
`else
  task automatic test_back_to_back();
    tests_run++;
    if (rise_t.size() < 39) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count got %0d rises want >=39", rise_t.size());
    end else begin
      tests_run++;
      if (rise_t[38] !== 293 || rise_b[38] !== {1'b0, 8'h80}) begin
        tests_failed++;
        $display("[TB] FAIL b2b_next_frame got t=%0d b=%h want t=293 b=080", rise_t[38], rise_b[38]);
      end
    end
  endtask

  task automatic test_no_tearing();
    wait_rel(320);
    line1 = TXTA;
    wait_rel(660);
    tests_run++;
    if (rise_b.size() < 89) begin
      tests_failed++;
      $display("[TB] FAIL tear_count got %0d rises want >=89", rise_b.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        tests_run++;
        if (rise_b[39 + i] !== {1'b1, char_at(TXT1, i)}) begin
          tests_failed++;
          $display("[TB] FAIL tear_old%0d got %h want %h", i, rise_b[39 + i], {1'b1, char_at(TXT1, i)});
        end
        tests_run++;
        if (rise_b[73 + i] !== {1'b1, 8'h41}) begin
          tests_failed++;
          $display("[TB] FAIL tear_new%0d got %h want 141", i, rise_b[73 + i]);
        end
      end
    end
    tests_run++;
    if (fd_t.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL tear_frames got %0d want 2", fd_t.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    wait_rel(708);
    tests_run++;
    if (lcd_e !== 1'b1 || lcd_rs !== 1'b1 || lcd_data !== 8'h30) begin
      tests_failed++;
      $display("[TB] FAIL midframe_slot got e=%b rs=%b d=%h want e=1 rs=1 d=30", lcd_e, lcd_rs, lcd_data);
    end
    tests_run++;
    if (stab_err != 0) begin
      tests_failed++;
      $display("[TB] FAIL bus_stable got %0d violations want 0", stab_err);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (lcd_e !== 1'b0 || lcd_rs !== 1'b0 || lcd_data !== 8'h00 || init_done !== 1'b0 || frame_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midframe_reset got e=%b rs=%b d=%h id=%b fd=%b want all 0",
               lcd_e, lcd_rs, lcd_data, init_done, frame_done);
    end
    release_reset();
    check_init("reinit");
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    line1 = TXT1;
    line2 = TXT2;
    test_reset();
    test_power_init();
    test_frame();
`ifdef LCD_CHANGE_DETECT_EN
    test_change_detect();
`else
    test_back_to_back();
    test_no_tearing();
    test_reset_mid_frame();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
